// File: rtl/dual_rail_pkg.sv
// dual_rail_pkg: shared definitions for the dual-rail transmitter.
//   - enc_t / ENC_FP / ENC_TP : link encoding selectors ("FP" four-phase, "TP" two-phase)
//   - RAIL_T / RAIL_F         : rail indices within a bit pair (true / false rail)
//   - SPACER                  : four-phase return-to-zero rail pair
//   - state_t                 : transmitter FSM states
//   - dr_encode()             : single bit -> one-hot rail pair
package dual_rail_pkg;

  typedef logic [15:0] enc_t;

  // Two-character ASCII tags so the parameter can be given as "FP" / "TP".
  localparam enc_t ENC_FP = 16'h4650;
  localparam enc_t ENC_TP = 16'h5450;

  localparam int RAIL_T = 1;
  localparam int RAIL_F = 0;

  localparam logic [1:0] SPACER = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DATA   = 2'b01,
    ST_SPACER = 2'b10,
    ST_WAIT   = 2'b11
  } state_t;

  // One-hot rail pair for a data bit: true rail for 1, false rail for 0.
  function automatic logic [1:0] dr_encode(input logic b);
    logic [1:0] pair;
    pair         = 2'b00;
    pair[RAIL_T] = b;
    pair[RAIL_F] = ~b;
    return pair;
  endfunction

endpackage

// File: rtl/dual_rail_tx_bit_sync.sv
// bit_sync: multi-flop synchronizer for a single asynchronous level.
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset (chain clears to 0)
//   d     in  asynchronous input
//   q     out synchronized output, STAGES clock edges after d settles
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/dual_rail_tx.sv
// dual_rail_tx: clocked transmitter onto a dual-rail delay-insensitive link.
// Accepts single-rail words on a valid/ready handshake, encodes each bit onto
// a rail pair and sequences a four-phase (return-to-spacer) or two-phase
// (transition) protocol against a synchronized acknowledge.
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   in_data  in  word to transmit (sampled only in the accept cycle)
//   in_valid in  in_data valid
//   in_ready out transmitter can accept a word (registered)
//   out      out dual-rail link, [bit][rail], registered
//   ack      in  receiver acknowledge, asynchronous to clk
//   busy     out token in flight
//   err      out sticky ack-wait timeout flag, cleared only by reset
import dual_rail_pkg::*;

module dual_rail_tx #(
  parameter enc_t ENC         = ENC_FP,
  parameter int   WIDTH       = 2,
  parameter int   RAIL_NUM    = 2,
  parameter int   SYNC_STAGES = 2,
  parameter int   TIMEOUT     = 1024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [WIDTH-1:0]                   in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [WIDTH-1:0][RAIL_NUM-1:0]     out,
  input  logic                               ack,
  output logic                               busy,
  output logic                               err
);

  localparam logic IS_TP = (ENC == ENC_TP);
  localparam int   CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                            state_r;
  logic [WIDTH-1:0][RAIL_NUM-1:0]    out_r;
  logic [WIDTH-1:0][RAIL_NUM-1:0]    cw_s;
  logic [CNT_W-1:0]                  cnt_r;
  logic                              exp_ack_r;
  logic                              in_ready_r;
  logic                              busy_r;
  logic                              err_r;
  logic                              ack_s;

  bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack),
    .q     (ack_s)
  );

  // Codeword to launch on accept. Two-phase toggles exactly one rail per
  // bit relative to the current rail levels; four-phase drives it directly.
  generate
    if (IS_TP) begin : g_tp
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign cw_s[i] = out_r[i] ^ dr_encode(in_data[i]);
      end
    end else begin : g_fp
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign cw_s[i] = dr_encode(in_data[i]);
      end
    end
  endgenerate

  // Protocol FSM with timeout counter and registered link/handshake outputs.
  // The counter saturates at its last value once err is raised; the FSM
  // keeps waiting for ack regardless of err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      out_r      <= '0;
      cnt_r      <= '0;
      exp_ack_r  <= 1'b0;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            out_r      <= cw_s;
            exp_ack_r  <= ~ack_s;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            if (IS_TP) begin
              state_r <= ST_WAIT;
            end else begin
              state_r <= ST_DATA;
            end
          end else begin
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end
        end
        ST_DATA: begin
          if (ack_s) begin
            out_r   <= {WIDTH{SPACER}};
            cnt_r   <= '0;
            state_r <= ST_SPACER;
          end else if (cnt_r == CNT_LAST) begin
            err_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_SPACER: begin
          if (!ack_s) begin
            cnt_r      <= '0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end else if (cnt_r == CNT_LAST) begin
            err_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (ack_s == exp_ack_r) begin
            cnt_r      <= '0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end else if (cnt_r == CNT_LAST) begin
            err_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          out_r      <= '0;
          cnt_r      <= '0;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign out      = out_r;
  assign in_ready = in_ready_r;
  assign busy     = busy_r;
  assign err      = err_r;

endmodule
